io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- Peripheral-side endpoint for the core's IN/OUT instructions.
- Accepts single-cycle OUT strobes (the control unit's output_valid plus the register-file data) into a transmit FIFO and drains it to an external valid/ready sink.
- Buffers words from an external valid/ready source into a receive FIFO, whose head the core reads with IN and pops with a one-cycle acknowledge.
- Sits between the control unit/datapath and board-level I/O.

Parameters:
DATA_W, 16, word width; matches the core register width.
OUT_DEPTH, 4, transmit FIFO entries; power of two, at least 2.
IN_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
cpu_out_valid  input  1  one-cycle OUT strobe from the control unit.
cpu_out_data  input  DATA_W  word written by OUT; sampled when cpu_out_valid=1.
cpu_in_ack  input  1  one-cycle strobe; core consumed cpu_in_data (IN executed).
cpu_in_data  output  DATA_W  receive FIFO head; 0 when empty.
cpu_in_avail  output  1  receive FIFO non-empty.
ext_out_valid  output  1  transmit FIFO non-empty.
ext_out_data  output  DATA_W  transmit FIFO head.
ext_out_ready  input  1  external sink accepts when high together with ext_out_valid.
ext_in_valid  input  1  external source offers ext_in_data.
ext_in_data  input  DATA_W  incoming word.
ext_in_ready  output  1  receive FIFO not full.
out_overflow  output  1  sticky: an OUT strobe was dropped because the transmit FIFO was full.
clr_overflow  input  1  clears out_overflow.
out_count  output  $clog2(OUT_DEPTH)+1  transmit FIFO occupancy.
in_count  output  $clog2(IN_DEPTH)+1  receive FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Both FIFOs empty: pointers and counts 0.
  - out_overflow=0; ext_out_valid=0; cpu_in_avail=0; cpu_in_data=0; ext_in_ready=1.
  - Reset mid-transfer discards all buffered words; no partial handshake survives.
- Transmit FIFO:
  - Push on cpu_out_valid when not full, or when full and a pop happens in the same cycle.
  - Pop on ext_out_valid & ext_out_ready.
  - Latency: strobe at edge N -> ext_out_valid=1 and ext_out_data valid after edge N.
  - ext_out_data is held stable while ext_out_valid=1 and ext_out_ready=0.
  - Simultaneous push and pop: count unchanged, order preserved.
- Overflow:
  - cpu_out_valid while full with no pop in that cycle: word dropped, out_overflow set after that edge, FIFO contents unchanged.
  - clr_overflow clears out_overflow.
  - clr_overflow and a new drop in the same cycle: set wins.
- Receive FIFO:
  - Push on ext_in_valid & ext_in_ready. ext_in_ready is combinational !full, so the external side never drops data.
  - Pop on cpu_in_ack when non-empty. cpu_in_ack while empty is ignored; no state change.
  - Latency: handshake at edge N -> cpu_in_avail=1 and cpu_in_data valid after edge N.
  - After a pop, cpu_in_data shows the next entry after the edge, or 0 if empty.
  - Full with a simultaneous pop: ext_in_ready stays 0 that cycle (derived from registered count); the push occurs next cycle.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH.
- Counts: range 0..DEPTH inclusive; full when count==DEPTH.
- No combinational path from cpu_out_valid to any ext_* output, nor from ext_in_valid to any cpu_* output.
- The two FIFOs are fully independent and may push and pop every cycle.

Test Plan:
- Reset, then cpu_out_valid for one cycle with data 0x1234, ext_out_ready=0 -> after the edge ext_out_valid=1, ext_out_data=0x1234, out_count=1; data held for 5 cycles; raise ready -> one transfer, then ext_out_valid=0.
- Strobe 0xA001..0xA005 on consecutive cycles with ready=0, OUT_DEPTH=4 -> out_count=4, out_overflow=1, 0xA005 lost; drain -> order 0xA001..0xA004; pulse clr_overflow -> out_overflow=0.
- Transmit FIFO full (4 entries), ready=1 and strobe 0xBEEF in the same cycle -> no overflow, count stays 4, 0xBEEF emerges last.
- ext_in_valid with 0x0042 then 0x0043, then cpu_in_ack -> cpu_in_avail=1 and cpu_in_data=0x0042 one cycle after the first handshake; after the ack cpu_in_data=0x0043; second ack -> cpu_in_avail=0, cpu_in_data=0; extra ack while empty -> no change.
- Hold ext_in_valid with 5 distinct words, no acks -> ext_in_ready=0 after 4 accepts, in_count=4; one ack -> the fifth word accepted on the following cycle.
- Fill both FIFOs to 3, assert rst for one cycle -> all counts 0, ext_out_valid=0, cpu_in_avail=0, out_overflow=0, ext_in_ready=1.

Source files
------------

// File: rtl/io_port_bridge.sv
// io_port_bridge: endpoint for the core's IN/OUT instructions.
// Transmit FIFO feeds an external sink; receive FIFO feeds the core.
module io_port_bridge #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_out_valid,
    input  logic [DATA_W-1:0]            cpu_out_data,
    input  logic                         cpu_in_ack,
    output logic [DATA_W-1:0]            cpu_in_data,
    output logic                         cpu_in_avail,
    output logic                         ext_out_valid,
    output logic [DATA_W-1:0]            ext_out_data,
    input  logic                         ext_out_ready,
    input  logic                         ext_in_valid,
    input  logic [DATA_W-1:0]            ext_in_data,
    output logic                         ext_in_ready,
    output logic                         out_overflow,
    input  logic                         clr_overflow,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic [$clog2(IN_DEPTH):0]    in_count
);

    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OCW = OAW + 1;
    localparam int ICW = IAW + 1;

    logic [DATA_W-1:0] tx_mem [OUT_DEPTH];
    logic [OAW-1:0]    tx_wr;
    logic [OAW-1:0]    tx_rd;
    logic [OCW-1:0]    tx_cnt;
    logic              tx_full;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_drop;

    logic [DATA_W-1:0] rx_mem [IN_DEPTH];
    logic [IAW-1:0]    rx_wr;
    logic [IAW-1:0]    rx_rd;
    logic [ICW-1:0]    rx_cnt;
    logic              rx_full;
    logic              rx_push;
    logic              rx_pop;

    // A full transmit FIFO still accepts a strobe if a word leaves the same cycle.
    assign tx_full       = (tx_cnt == OCW'(OUT_DEPTH));
    assign ext_out_valid = (tx_cnt != '0);
    assign tx_pop        = ext_out_valid & ext_out_ready;
    assign tx_push       = cpu_out_valid & (~tx_full | tx_pop);
    assign tx_drop       = cpu_out_valid & tx_full & ~tx_pop;
    assign ext_out_data  = tx_mem[tx_rd];
    assign out_count     = tx_cnt;

    // Ready comes from the registered count only, so a pop while full
    // does not open the input until the following cycle.
    assign rx_full      = (rx_cnt == ICW'(IN_DEPTH));
    assign ext_in_ready = ~rx_full;
    assign rx_push      = ext_in_valid & ext_in_ready;
    assign cpu_in_avail = (rx_cnt != '0);
    assign rx_pop       = cpu_in_ack & cpu_in_avail;
    assign cpu_in_data  = cpu_in_avail ? rx_mem[rx_rd] : '0;
    assign in_count     = rx_cnt;

    // Transmit storage write; contents need no reset, the count guards them.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= cpu_out_data;
        end
    end

    // Transmit pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + OAW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + OAW'(1);
            end
            if (tx_push && !tx_pop) begin
                tx_cnt <= tx_cnt + OCW'(1);
            end else if (tx_pop && !tx_push) begin
                tx_cnt <= tx_cnt - OCW'(1);
            end
        end
    end

    // Sticky overflow flag; a fresh drop beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_overflow <= 1'b0;
        end else if (tx_drop) begin
            out_overflow <= 1'b1;
        end else if (clr_overflow) begin
            out_overflow <= 1'b0;
        end
    end

    // Receive storage write.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr] <= ext_in_data;
        end
    end

    // Receive pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_wr <= rx_wr + IAW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + IAW'(1);
            end
            if (rx_push && !rx_pop) begin
                rx_cnt <= rx_cnt + ICW'(1);
            end else if (rx_pop && !rx_push) begin
                rx_cnt <= rx_cnt - ICW'(1);
            end
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed checks for io_port_bridge.
// Each task drives one scenario and compares against hand-computed values.
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_out_valid;
    logic [15:0] cpu_out_data;
    logic        cpu_in_ack;
    logic [15:0] cpu_in_data;
    logic        cpu_in_avail;
    logic        ext_out_valid;
    logic [15:0] ext_out_data;
    logic        ext_out_ready;
    logic        ext_in_valid;
    logic [15:0] ext_in_data;
    logic        ext_in_ready;
    logic        out_overflow;
    logic        clr_overflow;
    logic [2:0]  out_count;
    logic [2:0]  in_count;

    int checks = 0;
    int errors = 0;

    io_port_bridge #(
        .DATA_W(16),
        .OUT_DEPTH(4),
        .IN_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_out_valid(cpu_out_valid),
        .cpu_out_data(cpu_out_data),
        .cpu_in_ack(cpu_in_ack),
        .cpu_in_data(cpu_in_data),
        .cpu_in_avail(cpu_in_avail),
        .ext_out_valid(ext_out_valid),
        .ext_out_data(ext_out_data),
        .ext_out_ready(ext_out_ready),
        .ext_in_valid(ext_in_valid),
        .ext_in_data(ext_in_data),
        .ext_in_ready(ext_in_ready),
        .out_overflow(out_overflow),
        .clr_overflow(clr_overflow),
        .out_count(out_count),
        .in_count(in_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ext_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ext_out_valid: got %b expected 0", ext_out_valid);
        end
        checks++;
        if (cpu_in_avail !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_in_avail: got %b expected 0", cpu_in_avail);
        end
        checks++;
        if (cpu_in_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cpu_in_data: got %h expected 0000", cpu_in_data);
        end
        checks++;
        if (ext_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ext_in_ready: got %b expected 1", ext_in_ready);
        end
        checks++;
        if (out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b expected 0", out_overflow);
        end
        checks++;
        if (out_count !== 3'd0 || in_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_counts: got out=%0d in=%0d expected 0 0",
                     out_count, in_count);
        end
    endtask

    task automatic test_single_out();
        cpu_out_valid = 1'b1;
        cpu_out_data  = 16'h1234;
        tick();
        cpu_out_valid = 1'b0;
        cpu_out_data  = 16'hFFFF;
        checks++;
        if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h1234
            || out_count !== 3'd1) begin
            errors++;
            $display("FAIL single_out_latency: got v=%b d=%h c=%0d expected 1 1234 1",
                     ext_out_valid, ext_out_data, out_count);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h1234) begin
                errors++;
                $display("FAIL single_out_hold[%0d]: got v=%b d=%h expected 1 1234",
                         i, ext_out_valid, ext_out_data);
            end
        end
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        checks++;
        if (ext_out_valid !== 1'b0 || out_count !== 3'd0) begin
            errors++;
            $display("FAIL single_out_drain: got v=%b c=%0d expected 0 0",
                     ext_out_valid, out_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            cpu_out_valid = 1'b1;
            cpu_out_data  = 16'hA000 + 16'(i);
            tick();
        end
        cpu_out_valid = 1'b0;
        checks++;
        if (out_count !== 3'd4 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got c=%0d ovf=%b expected 4 1",
                     out_count, out_overflow);
        end
        ext_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: got v=%b d=%h expected 1 %h",
                         i, ext_out_valid, ext_out_data, 16'hA000 + 16'(i));
            end
            tick();
        end
        ext_out_ready = 1'b0;
        checks++;
        if (ext_out_valid !== 1'b0 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after_drain: got v=%b ovf=%b expected 0 1",
                     ext_out_valid, out_overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b expected 0", out_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) begin
            cpu_out_valid = 1'b1;
            cpu_out_data  = 16'hC000 + 16'(i);
            tick();
        end
        ext_out_ready = 1'b1;
        cpu_out_data  = 16'hBEEF;
        tick();
        cpu_out_valid = 1'b0;
        checks++;
        if (out_count !== 3'd4 || out_overflow !== 1'b0
            || ext_out_data !== 16'hC002) begin
            errors++;
            $display("FAIL full_push_pop: got c=%0d ovf=%b d=%h expected 4 0 c002",
                     out_count, out_overflow, ext_out_data);
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp;
            exp = (i == 3) ? 16'hBEEF : 16'hC002 + 16'(i);
            checks++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== exp) begin
                errors++;
                $display("FAIL full_push_pop_order[%0d]: got v=%b d=%h expected 1 %h",
                         i, ext_out_valid, ext_out_data, exp);
            end
            tick();
        end
        ext_out_ready = 1'b0;
        checks++;
        if (out_count !== 3'd0) begin
            errors++;
            $display("FAIL full_push_pop_empty: got %0d expected 0", out_count);
        end
    endtask

    task automatic test_set_beats_clear();
        for (int i = 1; i <= 4; i++) begin
            cpu_out_valid = 1'b1;
            cpu_out_data  = 16'hD000 + 16'(i);
            tick();
        end
        cpu_out_data = 16'hD005;
        clr_overflow = 1'b1;
        tick();
        cpu_out_valid = 1'b0;
        clr_overflow  = 1'b0;
        checks++;
        if (out_overflow !== 1'b1 || out_count !== 3'd4
            || ext_out_data !== 16'hD001) begin
            errors++;
            $display("FAIL set_beats_clear: got ovf=%b c=%0d d=%h expected 1 4 d001",
                     out_overflow, out_count, ext_out_data);
        end
        clr_overflow  = 1'b1;
        ext_out_ready = 1'b1;
        repeat (4) tick();
        clr_overflow  = 1'b0;
        ext_out_ready = 1'b0;
        checks++;
        if (out_overflow !== 1'b0 || out_count !== 3'd0) begin
            errors++;
            $display("FAIL set_beats_clear_after: got ovf=%b c=%0d expected 0 0",
                     out_overflow, out_count);
        end
    endtask

    task automatic test_rx_basic();
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h0042;
        tick();
        checks++;
        if (cpu_in_avail !== 1'b1 || cpu_in_data !== 16'h0042) begin
            errors++;
            $display("FAIL rx_first: got a=%b d=%h expected 1 0042",
                     cpu_in_avail, cpu_in_data);
        end
        ext_in_data = 16'h0043;
        tick();
        ext_in_valid = 1'b0;
        checks++;
        if (in_count !== 3'd2 || cpu_in_data !== 16'h0042) begin
            errors++;
            $display("FAIL rx_two: got c=%0d d=%h expected 2 0042",
                     in_count, cpu_in_data);
        end
        cpu_in_ack = 1'b1;
        tick();
        cpu_in_ack = 1'b0;
        checks++;
        if (cpu_in_data !== 16'h0043 || in_count !== 3'd1) begin
            errors++;
            $display("FAIL rx_ack1: got d=%h c=%0d expected 0043 1",
                     cpu_in_data, in_count);
        end
        cpu_in_ack = 1'b1;
        tick();
        checks++;
        if (cpu_in_avail !== 1'b0 || cpu_in_data !== 16'h0000
            || in_count !== 3'd0) begin
            errors++;
            $display("FAIL rx_ack2: got a=%b d=%h c=%0d expected 0 0000 0",
                     cpu_in_avail, cpu_in_data, in_count);
        end
        tick();
        cpu_in_ack = 1'b0;
        checks++;
        if (cpu_in_avail !== 1'b0 || in_count !== 3'd0
            || ext_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_ack_empty: got a=%b c=%0d r=%b expected 0 0 1",
                     cpu_in_avail, in_count, ext_in_ready);
        end
    endtask

    task automatic test_rx_full();
        ext_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ext_in_data = 16'hE000 + 16'(i);
            tick();
        end
        ext_in_data = 16'hE005;
        checks++;
        if (ext_in_ready !== 1'b0 || in_count !== 3'd4) begin
            errors++;
            $display("FAIL rx_full: got r=%b c=%0d expected 0 4",
                     ext_in_ready, in_count);
        end
        tick();
        checks++;
        if (in_count !== 3'd4 || cpu_in_data !== 16'hE001) begin
            errors++;
            $display("FAIL rx_full_hold: got c=%0d d=%h expected 4 e001",
                     in_count, cpu_in_data);
        end
        cpu_in_ack = 1'b1;
        tick();
        cpu_in_ack = 1'b0;
        checks++;
        if (in_count !== 3'd3 || ext_in_ready !== 1'b1
            || cpu_in_data !== 16'hE002) begin
            errors++;
            $display("FAIL rx_full_pop: got c=%0d r=%b d=%h expected 3 1 e002",
                     in_count, ext_in_ready, cpu_in_data);
        end
        tick();
        ext_in_valid = 1'b0;
        checks++;
        if (in_count !== 3'd4) begin
            errors++;
            $display("FAIL rx_fifth_accept: got %0d expected 4", in_count);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (cpu_in_data !== 16'hE000 + 16'(i)) begin
                errors++;
                $display("FAIL rx_full_order[%0d]: got %h expected %h",
                         i, cpu_in_data, 16'hE000 + 16'(i));
            end
            cpu_in_ack = 1'b1;
            tick();
        end
        cpu_in_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) begin
            cpu_out_valid = 1'b1;
            cpu_out_data  = 16'h7000 + 16'(i);
            tick();
        end
        cpu_out_valid = 1'b0;
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        ext_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ext_in_data = 16'h8000 + 16'(i);
            tick();
        end
        ext_in_valid = 1'b0;
        checks++;
        if (out_count !== 3'd3 || in_count !== 3'd3 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got oc=%0d ic=%0d ovf=%b expected 3 3 1",
                     out_count, in_count, out_overflow);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_count !== 3'd0 || in_count !== 3'd0 || ext_out_valid !== 1'b0
            || cpu_in_avail !== 1'b0 || out_overflow !== 1'b0
            || ext_in_ready !== 1'b1 || cpu_in_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: got oc=%0d ic=%0d v=%b a=%b ovf=%b r=%b d=%h expected 0 0 0 0 0 1 0000",
                     out_count, in_count, ext_out_valid, cpu_in_avail,
                     out_overflow, ext_in_ready, cpu_in_data);
        end
        cpu_out_valid = 1'b1;
        cpu_out_data  = 16'h5555;
        ext_in_valid  = 1'b1;
        ext_in_data   = 16'h6666;
        tick();
        cpu_out_valid = 1'b0;
        ext_in_valid  = 1'b0;
        checks++;
        if (ext_out_data !== 16'h5555 || out_count !== 3'd1
            || cpu_in_data !== 16'h6666 || in_count !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_fresh: got od=%h oc=%0d id=%h ic=%0d expected 5555 1 6666 1",
                     ext_out_data, out_count, cpu_in_data, in_count);
        end
    endtask

    initial begin
        rst           = 1'b1;
        cpu_out_valid = 1'b0;
        cpu_out_data  = '0;
        cpu_in_ack    = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
        clr_overflow  = 1'b0;
        tick();
        test_reset();
        test_single_out();
        test_overflow();
        test_full_push_pop();
        test_set_beats_clear();
        test_rx_basic();
        test_rx_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
